// File: rtl/program_loader_if.sv
// Valid/ready word stream feeding the program loader.
// Master drives words; slave (the loader) returns ready.
interface program_loader_if #(
   parameter int unsigned DATA_W = 32
);

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/program_loader.sv
// Boot-time loader: parses header/payload stream, writes word pairs into the core's
// external-memory init ports, and holds the core in reset until the last segment lands.
module program_loader #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned CNT_W      = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   program_loader_if.slave       in_if,
   input  logic                  load_req,
   output logic                  enable_load_ex_mem,
   output logic [DM_ADDRESS-1:0] InstExMemAddress,
   output logic [DATA_W-1:0]     InstExMemData1,
   output logic [DATA_W-1:0]     InstExMemData2,
   output logic [DM_ADDRESS-1:0] DataExMemAddress,
   output logic [DATA_W-1:0]     DataExMemData1,
   output logic [DATA_W-1:0]     DataExMemData2,
   output logic                  cpu_reset,
   output logic                  done,
   output logic [DATA_W-1:0]     checksum
);

   typedef enum logic [2:0] {
      StHdr = 3'd0,
      StLo  = 3'd1,
      StHi  = 3'd2,
      StWr  = 3'd3,
      StRun = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic                  region_q, region_d;
   logic                  last_q, last_d;
   logic [DM_ADDRESS-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]     word1_q, word1_d;
   logic [DATA_W-1:0]     checksum_q, checksum_d;

   logic [DM_ADDRESS-1:0] inst_addr_q, inst_addr_d;
   logic [DATA_W-1:0]     inst_d1_q, inst_d1_d;
   logic [DATA_W-1:0]     inst_d2_q, inst_d2_d;
   logic [DM_ADDRESS-1:0] data_addr_q, data_addr_d;
   logic [DATA_W-1:0]     data_d1_q, data_d1_d;
   logic [DATA_W-1:0]     data_d2_q, data_d2_d;

   logic                  ready;
   logic                  xfer;
   logic [CNT_W-1:0]      hdr_cnt;

   // Ready is gated by reset so no word is taken while the loader is being cleared.
   assign ready   = reset & ((state_q == StHdr) | (state_q == StLo) | (state_q == StHi));
   assign xfer    = in_if.in_valid & ready;
   assign hdr_cnt = in_if.in_data[CNT_W-1:0];

   assign in_if.in_ready = ready;

   always_comb begin
      state_d     = state_q;
      region_d    = region_q;
      last_d      = last_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      word1_d     = word1_q;
      checksum_d  = checksum_q;
      inst_addr_d = inst_addr_q;
      inst_d1_d   = inst_d1_q;
      inst_d2_d   = inst_d2_q;
      data_addr_d = data_addr_q;
      data_d1_d   = data_d1_q;
      data_d2_d   = data_d2_q;

      unique case (state_q)
         StHdr: begin
            if (xfer) begin
               region_d = in_if.in_data[DATA_W-1];
               last_d   = in_if.in_data[DATA_W-2];
               addr_d   = in_if.in_data[16 +: DM_ADDRESS];
               cnt_d    = hdr_cnt;
               if (hdr_cnt != '0) begin
                  state_d = StLo;
               end else if (in_if.in_data[DATA_W-2]) begin
                  state_d = StRun;
               end
            end
         end
         StLo: begin
            if (xfer) begin
               word1_d    = in_if.in_data;
               checksum_d = checksum_q ^ in_if.in_data;
               state_d    = StHi;
            end
         end
         StHi: begin
            if (xfer) begin
               checksum_d = checksum_q ^ in_if.in_data;
               // Init outputs change only here, so they are stable throughout WR.
               if (region_q) begin
                  data_addr_d = addr_q;
                  data_d1_d   = word1_q;
                  data_d2_d   = in_if.in_data;
               end else begin
                  inst_addr_d = addr_q;
                  inst_d1_d   = word1_q;
                  inst_d2_d   = in_if.in_data;
               end
               state_d = StWr;
            end
         end
         StWr: begin
            if (cnt_q > CNT_W'(1)) begin
               cnt_d   = cnt_q - CNT_W'(1);
               addr_d  = addr_q + DM_ADDRESS'(1);
               state_d = StLo;
            end else if (last_q) begin
               state_d = StRun;
            end else begin
               state_d = StHdr;
            end
         end
         StRun: begin
            if (load_req) begin
               checksum_d = '0;
               state_d    = StHdr;
            end
         end
         default: begin
            state_d = StHdr;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StHdr;
         region_q    <= 1'b0;
         last_q      <= 1'b0;
         addr_q      <= '0;
         cnt_q       <= '0;
         word1_q     <= '0;
         checksum_q  <= '0;
         inst_addr_q <= '0;
         inst_d1_q   <= '0;
         inst_d2_q   <= '0;
         data_addr_q <= '0;
         data_d1_q   <= '0;
         data_d2_q   <= '0;
      end else begin
         state_q     <= state_d;
         region_q    <= region_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         word1_q     <= word1_d;
         checksum_q  <= checksum_d;
         inst_addr_q <= inst_addr_d;
         inst_d1_q   <= inst_d1_d;
         inst_d2_q   <= inst_d2_d;
         data_addr_q <= data_addr_d;
         data_d1_q   <= data_d1_d;
         data_d2_q   <= data_d2_d;
      end
   end

   assign enable_load_ex_mem = (state_q == StWr);
   assign cpu_reset          = (state_q != StRun);
   assign done               = (state_q == StRun);
   assign checksum           = checksum_q;
   assign InstExMemAddress   = inst_addr_q;
   assign InstExMemData1     = inst_d1_q;
   assign InstExMemData2     = inst_d2_q;
   assign DataExMemAddress   = data_addr_q;
   assign DataExMemData1     = data_d1_q;
   assign DataExMemData2     = data_d2_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scoreboard of expected init-port strobes,
// compared by a negedge monitor whenever the write strobe fires.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_req = 1'b0;
   logic        en;
   logic [8:0]  iaddr, daddr;
   logic [31:0] id1, id2, dd1, dd2, cks;
   logic        cpu_reset, done;

   always #5 clk = ~clk;

   program_loader_if #(.DATA_W(32)) bus ();

   program_loader #(
      .DATA_W    (32),
      .DM_ADDRESS(9),
      .CNT_W     (9)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .in_if             (bus),
      .load_req          (load_req),
      .enable_load_ex_mem(en),
      .InstExMemAddress  (iaddr),
      .InstExMemData1    (id1),
      .InstExMemData2    (id2),
      .DataExMemAddress  (daddr),
      .DataExMemData1    (dd1),
      .DataExMemData2    (dd2),
      .cpu_reset         (cpu_reset),
      .done              (done),
      .checksum          (cks)
   );

   typedef struct packed {
      logic [8:0]  ia;
      logic [31:0] i1;
      logic [31:0] i2;
      logic [8:0]  da;
      logic [31:0] d1;
      logic [31:0] d2;
   } exp_t;

   exp_t        sb[$];
   exp_t        m;
   exp_t        mon_e;
   logic [31:0] m_cks;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_strobe = 0;
   int          strobe_gap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every strobe must match the oldest queued expectation, both regions included.
   always @(negedge clk) begin
      if (en === 1'b1) begin
         check("strobe_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("inst_addr", 32'(iaddr), 32'(mon_e.ia));
            check("inst_data1", id1, mon_e.i1);
            check("inst_data2", id2, mon_e.i2);
            check("data_addr", 32'(daddr), 32'(mon_e.da));
            check("data_data1", dd1, mon_e.d1);
            check("data_data2", dd2, mon_e.d2);
         end
         check("in_ready_in_wr", 32'(bus.in_ready), 32'd0);
         strobe_gap  = cyc - last_strobe;
         last_strobe = cyc;
      end
   end

   function automatic logic [31:0] hdr(input bit r, input bit l, input logic [8:0] a,
                                       input logic [8:0] n);
      return {r, l, 5'h15, a, 7'h2A, n};
   endfunction

   task automatic send(input logic [31:0] w, input bit gap);
      int n = 0;
      if (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic seg(input bit region, input bit last, input logic [8:0] addr, input int n,
                      input bit gap);
      logic [8:0]  a = addr;
      logic [31:0] w1, w2;
      send(hdr(region, last, addr, 9'(n)), gap);
      for (int i = 0; i < n; i++) begin
         w1 = $urandom;
         w2 = $urandom;
         send(w1, gap);
         m_cks ^= w1;
         if (region) begin
            m.da = a;
            m.d1 = w1;
            m.d2 = w2;
         end else begin
            m.ia = a;
            m.i1 = w1;
            m.i2 = w2;
         end
         sb.push_back(m);
         send(w2, gap);
         m_cks ^= w2;
         a = a + 9'd1;
      end
   endtask

   task automatic expect_run();
      @(negedge clk);
      @(negedge clk);
      check("run_done", 32'(done), 32'd1);
      check("run_cpu_reset", 32'(cpu_reset), 32'd0);
      check("run_in_ready", 32'(bus.in_ready), 32'd0);
      check("run_checksum", cks, m_cks);
      check("run_sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic expect_hdr();
      @(negedge clk);
      @(negedge clk);
      check("hdr_done", 32'(done), 32'd0);
      check("hdr_cpu_reset", 32'(cpu_reset), 32'd1);
      check("hdr_in_ready", 32'(bus.in_ready), 32'd1);
      check("hdr_sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      load_req     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_en", 32'(en), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_checksum", cks, 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_inst_addr", 32'(iaddr), 32'd0);
      check("rst_inst_d1", id1, 32'd0);
      check("rst_inst_d2", id2, 32'd0);
      check("rst_data_addr", 32'(daddr), 32'd0);
      check("rst_data_d1", dd1, 32'd0);
      check("rst_data_d2", dd2, 32'd0);
      m     = '0;
      m_cks = '0;
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      m            = '0;
      m_cks        = '0;

      // Back-to-back inst segment, then RUN.
      do_reset();
      seg(1'b0, 1'b1, 9'h004, 2, 1'b0);
      expect_run();
      check("strobe_spacing", 32'(strobe_gap), 32'd3);

      // Data segment wrapping past 0x1FF, then a single inst entry.
      do_reset();
      seg(1'b1, 1'b0, 9'h1FF, 2, 1'b0);
      expect_hdr();
      check("wrap_data_addr", 32'(daddr), 32'h000);
      seg(1'b0, 1'b1, 9'h0AB, 1, 1'b0);
      expect_run();

      // Empty non-last header is ignored; empty last header enters RUN.
      do_reset();
      send(hdr(1'b0, 1'b0, 9'h055, 9'd0), 1'b0);
      @(negedge clk);
      check("empty_hdr_stay", 32'(bus.in_ready), 32'd1);
      check("empty_hdr_done", 32'(done), 32'd0);
      send(hdr(1'b1, 1'b1, 9'h066, 9'd0), 1'b0);
      expect_run();

      // in_valid toggled every other cycle across two segments.
      do_reset();
      seg(1'b0, 1'b0, 9'h040, 3, 1'b1);
      expect_hdr();
      seg(1'b1, 1'b1, 9'h080, 2, 1'b1);
      expect_run();

      // Reset while in HI drops the partial pair; a fresh segment still loads.
      do_reset();
      send(hdr(1'b0, 1'b1, 9'h010, 9'd2), 1'b0);
      send(32'hCAFE_0001, 1'b0);
      do_reset();
      seg(1'b0, 1'b1, 9'h020, 2, 1'b0);
      expect_run();

      // In RUN, stream is ignored; load_req restarts and a reload completes.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h4003_0001;
      repeat (3) @(negedge clk);
      check("run_ignore_cks", cks, m_cks);
      check("run_ignore_done", 32'(done), 32'd1);
      load_req     = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      load_req = 1'b0;
      check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
      check("reload_done", 32'(done), 32'd0);
      check("reload_checksum", cks, 32'd0);
      check("reload_in_ready", 32'(bus.in_ready), 32'd1);
      check("reload_keep_iaddr", 32'(iaddr), 32'(m.ia));
      check("reload_keep_id2", id2, m.i2);
      m_cks = '0;
      seg(1'b1, 1'b1, 9'h033, 1, 1'b0);
      expect_run();

      check("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
